// File: rtl/round_seq_pkg.sv
// Shared types and constants for the round sequencer: the FSM state
// encoding, counter widths and the shortest legal symbol period.
package round_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        GENERATE   = 3'd2,
        ANSWER     = 3'd3,
        CHECK      = 3'd4,
        WAIT_LEVEL = 3'd5,
        DONE       = 3'd6
    } state_t;

    localparam int COUNT_W = 4;
    localparam int LIVES_W = 2;
    localparam logic [31:0] MIN_PERIOD = 32'd2;

    // A period below 2 would tick every cycle or never; clamp it.
    function automatic logic [31:0] clamp_period(input logic [31:0] period);
        return (period < MIN_PERIOD) ? MIN_PERIOD : period;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Loadable 32-bit period counter. While enabled it counts 0..period-1 and
// flags the last count; dropping the enable returns the count to zero so
// every enabled stretch starts from a clean phase.
module tick_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] count;

    assign tick = en && (count == period - 32'd1);

    // Advance while enabled, wrap on the tick, hold at zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Game-round scheduler: countdown, paced symbol generation, answer
// collection and scoring, with lives tracking and level-up handshake.
// Optional answer timeout enabled by defining ROUND_SEQ_ANSWER_TIMEOUT_EN.
module round_sequencer
    import round_seq_pkg::*;
#(
    parameter int SYMS_PER_ROUND   = 8,
    parameter int LIVES            = 3,
    parameter int COUNTDOWN_CYCLES = 100000000,
    parameter int ANSWER_TIMEOUT   = 500000000
) (
    input  logic        Clk100M,
    input  logic        Rst_n,
    input  logic        start,
    input  logic [31:0] symGenMax,
    input  logic        newLevel,
    input  logic        victory,
    input  logic        symIsTarget,
    input  logic        ansValid,
    input  logic [3:0]  ansCount,
    output logic        symTick,
    output logic        incLevel,
    output logic        roundActive,
    output logic [1:0]  lives,
    output logic        gameOver,
    output logic [3:0]  targetCount,
    output logic [2:0]  state
);

    localparam logic [COUNT_W-1:0] SYM_LAST = COUNT_W'(SYMS_PER_ROUND - 1);

    state_t             cur_state;
    logic [31:0]        sym_period;
    logic [COUNT_W-1:0] sym_cnt;
    logic               ans_match;
    logic [31:0]        div_period;
    logic               div_en;
    logic               div_tick;

    // One divider serves the countdown, the symbol pacing and the answer
    // timeout, since those phases never overlap.
    always_comb begin
        div_period = sym_period;
        div_en     = 1'b0;
        case (cur_state)
            COUNTDOWN: begin
                div_period = 32'(COUNTDOWN_CYCLES);
                div_en     = 1'b1;
            end
            GENERATE: begin
                div_en = 1'b1;
            end
            ANSWER: begin
                div_period = 32'(ANSWER_TIMEOUT);
`ifdef ROUND_SEQ_ANSWER_TIMEOUT_EN
                div_en = 1'b1;
`else
                div_en = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    tick_divider u_div (
        .clk    (Clk100M),
        .rst_n  (Rst_n),
        .en     (div_en),
        .period (div_period),
        .tick   (div_tick)
    );

    assign symTick     = (cur_state == GENERATE) && div_tick;
    assign roundActive = (cur_state == COUNTDOWN) || (cur_state == GENERATE) ||
                         (cur_state == ANSWER);
    assign state       = cur_state;

    // Round FSM with its scoring registers.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            cur_state   <= IDLE;
            sym_period  <= MIN_PERIOD;
            sym_cnt     <= '0;
            ans_match   <= 1'b0;
            incLevel    <= 1'b0;
            lives       <= LIVES_W'(LIVES);
            gameOver    <= 1'b0;
            targetCount <= '0;
        end else begin
            incLevel <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (start) cur_state <= COUNTDOWN;
                end
                COUNTDOWN: begin
                    if (div_tick) begin
                        targetCount <= '0;
                        sym_cnt     <= '0;
                        sym_period  <= clamp_period(symGenMax);
                        cur_state   <= GENERATE;
                    end
                end
                GENERATE: begin
                    if (div_tick) begin
                        if (symIsTarget && (targetCount != '1))
                            targetCount <= targetCount + COUNT_W'(1);
                        if (sym_cnt == SYM_LAST) cur_state <= ANSWER;
                        else                     sym_cnt   <= sym_cnt + COUNT_W'(1);
                    end
                end
                ANSWER: begin
                    if (ansValid) begin
                        ans_match <= (ansCount == targetCount);
                        incLevel  <= (ansCount == targetCount);
                        cur_state <= CHECK;
                    end
`ifdef ROUND_SEQ_ANSWER_TIMEOUT_EN
                    else if (div_tick) begin
                        ans_match <= 1'b0;
                        cur_state <= CHECK;
                    end
`endif
                end
                CHECK: begin
                    if (ans_match) begin
                        cur_state <= WAIT_LEVEL;
                    end else begin
                        lives <= lives - LIVES_W'(1);
                        if (lives == LIVES_W'(1)) begin
                            gameOver  <= 1'b1;
                            cur_state <= DONE;
                        end else begin
                            cur_state <= COUNTDOWN;
                        end
                    end
                end
                WAIT_LEVEL: begin
                    if (victory)       cur_state <= DONE;
                    else if (newLevel) cur_state <= COUNTDOWN;
                end
                DONE: ;
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer: correct round, wrong answers down to
// game over, period latching and clamping, victory priority, mid-round
// reset, answer timeout and target-count saturation.
module tb_round_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, new_level, victory, sym_is_target, ans_valid;
    logic [31:0] sym_gen_max;
    logic [3:0]  ans_count;
    logic        sym_tick, inc_level, round_active, game_over;
    logic [1:0]  lives;
    logic [3:0]  target_count;
    logic [2:0]  state;

    logic        start2;
    logic        sym_tick2, inc_level2, round_active2, game_over2;
    logic [1:0]  lives2;
    logic [3:0]  target_count2;
    logic [2:0]  state2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    round_sequencer #(.SYMS_PER_ROUND(8), .LIVES(3), .COUNTDOWN_CYCLES(4),
                      .ANSWER_TIMEOUT(20)) dut (
        .Clk100M(clk), .Rst_n(rst_n), .start(start), .symGenMax(sym_gen_max),
        .newLevel(new_level), .victory(victory), .symIsTarget(sym_is_target),
        .ansValid(ans_valid), .ansCount(ans_count), .symTick(sym_tick),
        .incLevel(inc_level), .roundActive(round_active), .lives(lives),
        .gameOver(game_over), .targetCount(target_count), .state(state)
    );

    round_sequencer #(.SYMS_PER_ROUND(15), .LIVES(3), .COUNTDOWN_CYCLES(4),
                      .ANSWER_TIMEOUT(20)) dut_sat (
        .Clk100M(clk), .Rst_n(rst_n), .start(start2), .symGenMax(32'd2),
        .newLevel(1'b0), .victory(1'b0), .symIsTarget(1'b1),
        .ansValid(1'b0), .ansCount(4'd0), .symTick(sym_tick2),
        .incLevel(inc_level2), .roundActive(round_active2), .lives(lives2),
        .gameOver(game_over2), .targetCount(target_count2), .state(state2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_sym(output int n);
        n = 0;
        while (!sym_tick && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) chk("sym_tick_seen", 32'd0, 32'd1);
    endtask

    // Walks a whole GENERATE phase, driving target flags from mask[i] on
    // tick i (1-based); returns the spacing before tick 2 and the last tick.
    task automatic run_gen(input logic [15:0] mask, input int nsyms,
                           input int change_at, input logic [31:0] new_max,
                           output int gap2, output int gap_last);
        int n;
        gap2 = 0;
        gap_last = 0;
        for (int i = 1; i <= nsyms; i++) begin
            wait_sym(n);
            if (i == 2)     gap2 = n + 1;
            if (i == nsyms) gap_last = n + 1;
            sym_is_target = mask[i];
            step(1);
            sym_is_target = 1'b0;
            if (i == change_at) sym_gen_max = new_max;
        end
    endtask

    task automatic answer(input logic [3:0] value);
        ans_count = value;
        ans_valid = 1'b1;
        step(1);
        ans_valid = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int g2, gl;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; new_level = 1'b0;
        victory = 1'b0; sym_is_target = 1'b0; ans_valid = 1'b0;
        ans_count = 4'd0; sym_gen_max = 32'd10;
        step(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_gameover", 32'(game_over), 32'd0);
        chk("rst_symtick", 32'(sym_tick), 32'd0);
        chk("rst_inclevel", 32'(inc_level), 32'd0);
        chk("rst_target", 32'(target_count), 32'd0);
        chk("rst_active", 32'(round_active), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Saturation: 15 targets out of 15 on the second instance.
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        step(36);
        chk("sat_state", 32'(state2), 32'd3);
        chk("sat_target", 32'(target_count2), 32'd15);

        // Round 1: correct answer, targets on ticks 1, 3, 6.
        pulse_start();
        chk("r1_countdown", 32'(state), 32'd1);
        chk("r1_active", 32'(round_active), 32'd1);
        step(4);
        chk("r1_generate", 32'(state), 32'd2);
        run_gen(16'b0000_0000_0100_1010, 8, 0, 32'd0, g2, gl);
        chk("r1_gap2", 32'(g2), 32'd10);
        chk("r1_gaplast", 32'(gl), 32'd10);
        chk("r1_answer", 32'(state), 32'd3);
        chk("r1_target", 32'(target_count), 32'd3);
        answer(4'd3);
        chk("r1_check", 32'(state), 32'd4);
        chk("r1_inc_hi", 32'(inc_level), 32'd1);
        step(1);
        chk("r1_wait", 32'(state), 32'd5);
        chk("r1_inc_lo", 32'(inc_level), 32'd0);
        new_level = 1'b1;
        step(1);
        new_level = 1'b0;
        chk("r1_newlevel", 32'(state), 32'd1);

        // Round 2: period changed to 6 mid-round, wrong answer.
        step(4);
        run_gen(16'h0000, 8, 1, 32'd6, g2, gl);
        chk("r2_gap2", 32'(g2), 32'd10);
        chk("r2_gaplast", 32'(gl), 32'd10);
        answer(4'd7);
        chk("r2_inc_lo", 32'(inc_level), 32'd0);
        step(1);
        chk("r2_state", 32'(state), 32'd1);
        chk("r2_lives", 32'(lives), 32'd2);

        // Round 3: new period 6 picked up; request period 1 for next round.
        step(4);
        run_gen(16'h0000, 8, 1, 32'd1, g2, gl);
        chk("r3_gap2", 32'(g2), 32'd6);
        answer(4'd7);
        step(1);
        chk("r3_lives", 32'(lives), 32'd1);

        // Round 4: period 1 clamps to 2; third miss ends the game.
        step(4);
        run_gen(16'h0000, 8, 0, 32'd0, g2, gl);
        chk("r4_gap2", 32'(g2), 32'd2);
        answer(4'd7);
        step(1);
        chk("r4_done", 32'(state), 32'd6);
        chk("r4_gameover", 32'(game_over), 32'd1);
        chk("r4_lives", 32'(lives), 32'd0);
        pulse_start();
        step(2);
        chk("done_sticky", 32'(state), 32'd6);

        // Reset mid-GENERATE takes effect without a clock edge.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        sym_gen_max = 32'd10;
        pulse_start();
        step(4 + 3);
        chk("mid_generate", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_lives", 32'(lives), 32'd3);
        step(1);
        rst_n = 1'b1;

        // Answer window: timeout build scores silence as a miss.
        pulse_start();
        step(4);
        run_gen(16'h0000, 8, 0, 32'd0, g2, gl);
        chk("to_answer", 32'(state), 32'd3);
`ifdef ROUND_SEQ_ANSWER_TIMEOUT_EN
        step(19);
        chk("to_still_answer", 32'(state), 32'd3);
        step(1);
        chk("to_check", 32'(state), 32'd4);
        step(1);
        chk("to_lives", 32'(lives), 32'd2);
        step(4);
`else
        step(30);
        chk("no_timeout", 32'(state), 32'd3);
        chk("no_timeout_lives", 32'(lives), 32'd3);
        answer(4'd7);
        step(1 + 4);
`endif

        // Victory together with newLevel: victory wins.
        run_gen(16'b0000_0000_0100_1010, 8, 0, 32'd0, g2, gl);
        answer(4'd3);
        chk("v_inc", 32'(inc_level), 32'd1);
        step(1);
        victory = 1'b1;
        new_level = 1'b1;
        step(1);
        victory = 1'b0;
        new_level = 1'b0;
        chk("v_done", 32'(state), 32'd6);
        chk("v_gameover", 32'(game_over), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
